bsg_tanh_pack: RTL and testbench
================================

BSG_TANH_PACK -- requirements
Module: bsg_tanh_pack

Interface
REQ-001 SHALL have parameter in_width_p, default 32, width of the signed Q16 tanh sample from the upstream tanh unit.
REQ-002 SHALL have parameter out_width_p, fixed at 16, width of one signed Q1.15 output lane.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports, in order:
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- tanh_i  in  in_width_p  signed Q16 sample
- v_i  in  1  sample valid
- ready_o  out  1  sample accepted when v_i & ready_o
- flush_i  in  1  single-cycle request to emit a half-filled word
- data_o  out  2*out_width_p  packed word: lane0 [15:0], lane1 [31:16]
- lanes_o  out  2  lane-valid mask of data_o (01 or 11)
- v_o  out  1  output word valid
- yumi_i  in  1  consumer takes head word; legal only when v_o=1
- sat_cnt_o  out  8  count of saturated samples

Function
REQ-005 SHALL convert each accepted sample x as y = (x + 1) arithmetically shifted right by 1, i.e. Q16 to Q15 with round-half-up.
REQ-006 SHALL clamp y to [-32768, 32767] and flag the sample as saturated only when clamping changes the value.
REQ-007 SHALL implement packer states eEMPTY (no held lane) and eHALF (lane0 held); reset state eEMPTY.
REQ-008 In eEMPTY, an accepted sample SHALL load lane0 and move to eHALF; ready_o SHALL be 1 in eEMPTY.
REQ-009 In eHALF, an accepted sample SHALL form lane1, push {lane1, lane0} with lanes 11 into the output FIFO, and return to eEMPTY.
REQ-010 In eHALF, ready_o SHALL equal FIFO-not-full, evaluated at the start of the cycle; no same-cycle push/pop pass-through when full.
REQ-011 SHALL hold a flush_pending bit, set by flush_i, and evaluate the pending condition as flush_i | flush_pending.
REQ-012 In eHALF with pending flush, no accepted sample, and FIFO not full, SHALL push {16'h0, lane0} with lanes 01, go to eEMPTY, and clear flush_pending.
REQ-013 In eHALF with pending flush and FIFO full, SHALL keep flush_pending set until the push occurs.
REQ-014 A sample accepted in eHALF in the same cycle as a pending flush SHALL push a full word (lanes 11) and clear flush_pending; no extra partial word is generated.
REQ-015 In eEMPTY, flush with no accepted sample SHALL be a no-op and clear flush_pending.
REQ-016 In eEMPTY, flush together with an accepted sample SHALL load lane0 and keep flush_pending; the partial push then follows under REQ-012/REQ-014.
REQ-017 SHALL provide a 2-entry output FIFO: data_o and lanes_o driven from the head entry, v_o = FIFO non-empty.
REQ-018 yumi_i SHALL pop the head; simultaneous push and pop on a non-full FIFO SHALL keep order and count correct.
REQ-019 data_o and lanes_o SHALL read 0 when v_o=0.
REQ-020 Latency: the word SHALL appear on v_o in the cycle after the completing accept or flush, when the FIFO is empty.
REQ-021 sat_cnt_o SHALL increment once per accepted saturated sample and stick at 255.
REQ-022 Assertion: yumi_i=1 while v_o=0 SHALL be flagged as an error in simulation.

Reset
REQ-023 reset_n_i=0 SHALL immediately, without waiting for a clock edge, force: eEMPTY, FIFO empty, flush_pending=0, v_o=0, data_o=0, lanes_o=0, sat_cnt_o=0, ready_o=1.
REQ-024 Reset mid-operation SHALL discard the held lane and all FIFO contents; the first accept after release SHALL load lane0.

Verification
REQ-025 Feed 0x00008000, then 0xFFFF8000 -> next cycle v_o=1, data_o=0xC0004000, lanes_o=11, sat_cnt_o=0.
REQ-026 Feed 0x00010000, then 0xFFFF0000 -> data_o=0x80007FFF, sat_cnt_o=1 (only the first sample saturates).
REQ-027 Feed 0x00000003, then pulse flush_i -> data_o=0x00000002, lanes_o=01; feeding 0xFFFFFFFD into lane0 yields 0xFFFF.
REQ-028 yumi_i=0; feed 5 samples -> 2 full words queued, 5th held in lane0, ready_o=0; after one yumi_i, ready_o=1 the next cycle.
REQ-029 Feed 300 samples of 0x7FFFFFFF -> sat_cnt_o=255 and stays 255.
REQ-030 Drop reset_n_i asynchronously with a full FIFO and eHALF -> v_o=0 and sat_cnt_o=0 before the next clock edge; ready_o=1.

Source files
------------

// File: rtl/bsg_tanh_pack.sv
// Converts signed Q16 tanh samples to saturated Q1.15 lanes and packs pairs
// into 32-bit words behind a 2-entry output FIFO, with partial-word flush.
module bsg_tanh_pack #(
  parameter int in_width_p  = 32,
  parameter int out_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [in_width_p-1:0]    tanh_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     flush_i,
  output logic [2*out_width_p-1:0] data_o,
  output logic [1:0]               lanes_o,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [7:0]               sat_cnt_o
);

  localparam int ext_w = in_width_p + 1;
  localparam logic signed [ext_w-1:0] max_c = ext_w'(2**(out_width_p-1) - 1);
  localparam logic signed [ext_w-1:0] min_c = ext_w'(-(2**(out_width_p-1)));

  typedef enum logic {eEMPTY, eHALF} state_e;

  typedef struct packed {
    logic [1:0]               lanes;
    logic [2*out_width_p-1:0] data;
  } entry_t;

  // One extra bit so x + 1 cannot overflow for the most positive input.
  logic signed [ext_w-1:0] x_ext, sum, y_full;
  logic [out_width_p-1:0]  y_lane;
  logic                    y_sat;

  assign x_ext  = signed'({tanh_i[in_width_p-1], tanh_i});
  assign sum    = x_ext + ext_w'(1);
  assign y_full = sum >>> 1;

  always_comb begin
    y_sat  = 1'b0;
    y_lane = y_full[out_width_p-1:0];
    if (y_full > max_c) begin
      y_sat  = 1'b1;
      y_lane = {1'b0, {(out_width_p-1){1'b1}}};
    end else if (y_full < min_c) begin
      y_sat  = 1'b1;
      y_lane = {1'b1, {(out_width_p-1){1'b0}}};
    end
  end

  state_e                 state_r, state_n;
  logic [out_width_p-1:0] lane0_r, lane0_n;
  logic                   flush_pend_r, flush_pend_n;
  logic                   pend, accept, push, pop;
  entry_t                 push_entry;
  entry_t                 mem_r [2];
  logic                   rd_ptr_r, wr_ptr_r;
  logic [1:0]             count_r;
  logic [7:0]             sat_cnt_r;
  logic                   fifo_full;
  entry_t                 head;

  assign fifo_full = (count_r == 2'd2);
  assign v_o       = (count_r != 2'd0);
  assign pop       = yumi_i & v_o;
  assign pend      = flush_i | flush_pend_r;
  assign head      = mem_r[rd_ptr_r];
  assign data_o    = v_o ? head.data  : '0;
  assign lanes_o   = v_o ? head.lanes : 2'b00;
  assign sat_cnt_o = sat_cnt_r;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_n      = state_r;
    lane0_n      = lane0_r;
    flush_pend_n = flush_pend_r;
    push         = 1'b0;
    push_entry   = '0;
    ready_o      = 1'b1;
    accept       = 1'b0;
    case (state_r)
      eEMPTY: begin
        ready_o = 1'b1;
        accept  = v_i;
        if (v_i) begin
          lane0_n      = y_lane;
          state_n      = eHALF;
          flush_pend_n = pend;
        end else begin
          flush_pend_n = 1'b0;
        end
      end
      eHALF: begin
        // Fullness is taken from the registered count: no pass-through when full.
        ready_o = ~fifo_full;
        accept  = v_i & ~fifo_full;
        if (accept) begin
          push         = 1'b1;
          push_entry   = '{lanes: 2'b11, data: {y_lane, lane0_r}};
          state_n      = eEMPTY;
          flush_pend_n = 1'b0;
        end else if (pend && !fifo_full) begin
          push         = 1'b1;
          push_entry   = '{lanes: 2'b01, data: {{out_width_p{1'b0}}, lane0_r}};
          state_n      = eEMPTY;
          flush_pend_n = 1'b0;
        end else begin
          flush_pend_n = pend;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= eEMPTY;
      lane0_r      <= '0;
      flush_pend_r <= 1'b0;
      rd_ptr_r     <= 1'b0;
      wr_ptr_r     <= 1'b0;
      count_r      <= 2'd0;
      sat_cnt_r    <= 8'd0;
    end else begin
      state_r      <= state_n;
      lane0_r      <= lane0_n;
      flush_pend_r <= flush_pend_n;
      if (push) wr_ptr_r <= ~wr_ptr_r;
      if (pop)  rd_ptr_r <= ~rd_ptr_r;
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (accept && y_sat && sat_cnt_r != 8'hFF) sat_cnt_r <= sat_cnt_r + 8'd1;
    end
  end

  // NOTE: FIFO storage is not reset; outputs are gated by v_o so stale data never leaks.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= push_entry;
  end

  yumi_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("bsg_tanh_pack: yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_tanh_pack.sv
// Directed, table-driven bench for bsg_tanh_pack: conversion/saturation rows
// plus hand-written flush, backpressure, saturation-counter and reset sequences.
module tb_bsg_tanh_pack;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] tanh_i;
  logic        v_i;
  logic        ready_o;
  logic        flush_i;
  logic [31:0] data_o;
  logic [1:0]  lanes_o;
  logic        v_o;
  logic        yumi_i;
  logic [7:0]  sat_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic [7:0]  exp_sat;
  } vec_t;

  vec_t vecs [6];

  bsg_tanh_pack #(.in_width_p(32), .out_width_p(16)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .tanh_i    (tanh_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .data_o    (data_o),
    .lanes_o   (lanes_o),
    .v_o       (v_o),
    .yumi_i    (yumi_i),
    .sat_cnt_o (sat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle with the given inputs applied at the preceding negedge.
  task automatic step(input logic v, input logic [31:0] x, input logic fl, input logic ym);
    @(negedge clk_i);
    v_i = v; tanh_i = x; flush_i = fl; yumi_i = ym;
    @(posedge clk_i);
    #1;
    v_i = 1'b0; flush_i = 1'b0; yumi_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] x);
    step(1'b1, x, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int accepted;
    int cycles;
    logic acc;

    vecs[0] = '{a: 32'h0000_8000, b: 32'hFFFF_8000, exp_data: 32'hC000_4000, exp_sat: 8'd0};
    vecs[1] = '{a: 32'h0001_0000, b: 32'hFFFF_0000, exp_data: 32'h8000_7FFF, exp_sat: 8'd1};
    vecs[2] = '{a: 32'hFFFF_FFFD, b: 32'h0000_0001, exp_data: 32'h0001_FFFF, exp_sat: 8'd1};
    vecs[3] = '{a: 32'hFFFE_FFFF, b: 32'h0000_0000, exp_data: 32'h0000_8000, exp_sat: 8'd1};
    vecs[4] = '{a: 32'hFFFE_FFFE, b: 32'h0000_FFFE, exp_data: 32'h7FFF_8000, exp_sat: 8'd2};
    vecs[5] = '{a: 32'h0000_FFFF, b: 32'h0000_0001, exp_data: 32'h0001_7FFF, exp_sat: 8'd3};

    reset_n_i = 1'b0; v_i = 1'b0; tanh_i = '0; flush_i = 1'b0; yumi_i = 1'b0;
    #23;
    check("reset v_o",     32'(v_o), 32'd0);
    check("reset data_o",  data_o, 32'd0);
    check("reset lanes_o", 32'(lanes_o), 32'd0);
    check("reset sat_cnt", 32'(sat_cnt_o), 32'd0);
    check("reset ready_o", 32'(ready_o), 32'd1);
    reset_n_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a);
      check("row lane0 not yet valid", 32'(v_o), 32'd0);
      send(vecs[i].b);
      check("row v_o", 32'(v_o), 32'd1);
      check("row data_o", data_o, vecs[i].exp_data);
      check("row lanes_o", 32'(lanes_o), 32'd3);
      check("row sat_cnt", 32'(sat_cnt_o), 32'(vecs[i].exp_sat));
      pop();
      check("row drained", 32'(v_o), 32'd0);
    end

    // Partial words via flush, including a negative lane0.
    send(32'h0000_0003);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush pos v_o", 32'(v_o), 32'd1);
    check("flush pos data_o", data_o, 32'h0000_0002);
    check("flush pos lanes_o", 32'(lanes_o), 32'd1);
    pop();
    send(32'hFFFF_FFFD);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush neg data_o", data_o, 32'h0000_FFFF);
    check("flush neg lanes_o", 32'(lanes_o), 32'd1);
    pop();

    // Flush while empty is a no-op and must not linger.
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("empty flush no push", 32'(v_o), 32'd0);
    send(32'h0000_0004);
    idle();
    check("empty flush cleared", 32'(v_o), 32'd0);
    send(32'h0000_0006);
    check("after empty flush data_o", data_o, 32'h0003_0002);
    check("after empty flush lanes_o", 32'(lanes_o), 32'd3);
    pop();

    // Flush with the sample that loads lane0: partial word follows.
    step(1'b1, 32'h0000_0010, 1'b1, 1'b0);
    check("flush+load no push yet", 32'(v_o), 32'd0);
    idle();
    check("flush+load v_o", 32'(v_o), 32'd1);
    check("flush+load data_o", data_o, 32'h0000_0008);
    check("flush+load lanes_o", 32'(lanes_o), 32'd1);
    pop();
    check("flush+load drained", 32'(v_o), 32'd0);

    // Flush with the completing sample: one full word, no extra partial.
    send(32'h0000_0010);
    step(1'b1, 32'h0000_0020, 1'b1, 1'b0);
    check("flush+complete data_o", data_o, 32'h0010_0008);
    check("flush+complete lanes_o", 32'(lanes_o), 32'd3);
    pop();
    idle();
    check("flush+complete no partial", 32'(v_o), 32'd0);

    // Simultaneous push and pop keeps order.
    send(32'h0000_0002);
    send(32'h0000_0004);
    send(32'h0000_0006);
    step(1'b1, 32'h0000_0008, 1'b0, 1'b1);
    check("push+pop v_o", 32'(v_o), 32'd1);
    check("push+pop data_o", data_o, 32'h0004_0003);
    pop();
    check("push+pop drained", 32'(v_o), 32'd0);

    // Backpressure, and a flush held while the FIFO is full.
    for (int k = 1; k <= 5; k++) send(32'(2 * k));
    check("full ready_o", 32'(ready_o), 32'd0);
    check("full head", data_o, 32'h0002_0001);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("full flush ready_o", 32'(ready_o), 32'd0);
    check("full flush head", data_o, 32'h0002_0001);
    pop();
    check("after pop ready_o", 32'(ready_o), 32'd1);
    check("after pop head", data_o, 32'h0004_0003);
    idle();
    check("held flush ready_o", 32'(ready_o), 32'd1);
    pop();
    check("held flush data_o", data_o, 32'h0000_0005);
    check("held flush lanes_o", 32'(lanes_o), 32'd1);
    pop();
    check("held flush drained", 32'(v_o), 32'd0);

    // Saturation counter sticks at 255.
    accepted = 0;
    cycles = 0;
    while (accepted < 300 && cycles < 2000) begin
      @(negedge clk_i);
      v_i = 1'b1; tanh_i = 32'h7FFF_FFFF; yumi_i = v_o;
      acc = ready_o;
      @(posedge clk_i);
      if (acc) accepted++;
      cycles++;
    end
    #1;
    v_i = 1'b0; yumi_i = 1'b0;
    check("sat samples accepted", 32'(accepted), 32'd300);
    check("sat_cnt at 255", 32'(sat_cnt_o), 32'd255);
    send(32'h7FFF_FFFF);
    check("sat_cnt stays 255", 32'(sat_cnt_o), 32'd255);

    // Fill to full FIFO in eHALF, then reset asynchronously mid-cycle.
    for (int k = 0; k < 10; k++) begin
      if (ready_o) send(32'h0000_0002);
    end
    check("pre-reset ready_o", 32'(ready_o), 32'd0);
    #1;
    reset_n_i = 1'b0;
    #1;
    check("async reset v_o", 32'(v_o), 32'd0);
    check("async reset sat_cnt", 32'(sat_cnt_o), 32'd0);
    check("async reset ready_o", 32'(ready_o), 32'd1);
    check("async reset data_o", data_o, 32'd0);
    check("async reset lanes_o", 32'(lanes_o), 32'd0);
    #1;
    reset_n_i = 1'b1;
    send(32'h0000_8000);
    check("post-reset lane0 only", 32'(v_o), 32'd0);
    send(32'hFFFF_8000);
    check("post-reset data_o", data_o, 32'hC000_4000);
    check("post-reset lanes_o", 32'(lanes_o), 32'd3);
    check("post-reset sat_cnt", 32'(sat_cnt_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
